// File: rtl/triangle_if.sv
// Triangle generator bus: step/enable/peak inputs and ramp level plus strobes.
interface triangle_if #(parameter int unsigned N = 8);
  logic         ena;
  logic         step;
  logic [N-1:0] max_level;
  logic [N-1:0] out;
  logic         dir;
  logic         at_peak;
  logic         at_trough;

  modport master (output ena, step, max_level, input out, dir, at_peak, at_trough);
  modport slave  (input ena, step, max_level, output out, dir, at_peak, at_trough);
endinterface

// File: rtl/triangle_generator.sv
// Step-driven triangle ramp 0 -> max_level -> 0 with peak/trough strobes.
// Optional macro TRIANGLE_DWELL_EN adds one hold step at each extremum.
module triangle_generator #(
  parameter int unsigned N = 8
) (
  input  logic       clk,
  input  logic       rst,
  triangle_if.slave  bus
);

`ifdef TRIANGLE_DWELL_EN
  typedef enum logic [1:0] {S_UP = 2'd0, S_DOWN = 2'd1, S_HOLD_HI = 2'd2, S_HOLD_LO = 2'd3} state_t;
  localparam state_t AFTER_PEAK   = S_HOLD_HI;
  localparam state_t AFTER_TROUGH = S_HOLD_LO;
`else
  typedef enum logic [0:0] {S_UP = 1'b0, S_DOWN = 1'b1} state_t;
  localparam state_t AFTER_PEAK   = S_DOWN;
  localparam state_t AFTER_TROUGH = S_UP;
`endif

  localparam logic [N-1:0] ZERO = '0;
  localparam logic [N-1:0] ONE  = N'(1);

  state_t       state, state_nxt;
  logic         step_q;
  logic         step_evt;
  logic [N-1:0] out_q, out_nxt;
  logic         dir_q, dir_nxt;
  logic         peak_q, peak_nxt;
  logic         trough_q, trough_nxt;

  // Step history is tracked regardless of ena so re-enabling never fakes an edge.
  assign step_evt = bus.ena & bus.step & ~step_q;

  always_comb begin
    state_nxt  = state;
    out_nxt    = out_q;
    peak_nxt   = 1'b0;
    trough_nxt = 1'b0;
    if (step_evt) begin
      if (bus.max_level == ZERO) begin
        out_nxt   = ZERO;
        state_nxt = S_UP;
      end else begin
        case (state)
          S_UP: begin
            if (out_q < bus.max_level) begin
              out_nxt = out_q + ONE;
              if (out_q + ONE == bus.max_level) begin
                peak_nxt  = 1'b1;
                state_nxt = AFTER_PEAK;
              end
            end else begin
              // Peak was lowered below the current level: clamp and turn around.
              out_nxt   = bus.max_level;
              peak_nxt  = 1'b1;
              state_nxt = AFTER_PEAK;
            end
          end
          S_DOWN: begin
            if (out_q != ZERO) begin
              out_nxt = out_q - ONE;
              if (out_q == ONE) begin
                trough_nxt = 1'b1;
                state_nxt  = AFTER_TROUGH;
              end
            end else begin
              state_nxt = S_UP;
            end
          end
`ifdef TRIANGLE_DWELL_EN
          S_HOLD_HI: state_nxt = S_DOWN;
          S_HOLD_LO: state_nxt = S_UP;
`endif
          default: state_nxt = S_UP;
        endcase
      end
    end
`ifdef TRIANGLE_DWELL_EN
    dir_nxt = (state_nxt == S_UP) || (state_nxt == S_HOLD_LO);
`else
    dir_nxt = (state_nxt == S_UP);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_UP;
      step_q   <= 1'b0;
      out_q    <= ZERO;
      dir_q    <= 1'b1;
      peak_q   <= 1'b0;
      trough_q <= 1'b0;
    end else begin
      state    <= state_nxt;
      step_q   <= bus.step;
      out_q    <= out_nxt;
      dir_q    <= dir_nxt;
      peak_q   <= peak_nxt;
      trough_q <= trough_nxt;
    end
  end

  assign bus.out       = out_q;
  assign bus.dir       = dir_q;
  assign bus.at_peak   = peak_q;
  assign bus.at_trough = trough_q;

endmodule

// File: tb/tb_triangle_generator.sv
// Scoreboard bench for triangle_generator: stimulus queues expected responses per cycle.
module tb_triangle_generator;

  typedef struct {
    int          cyc;
    logic [7:0]  o;
    logic        d;
    logic        p;
    logic        t;
    string       name;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;
  exp_t sb[$];

  logic [7:0] t_o [12];
  logic       t_d [12];
  logic       t_p [12];
  logic       t_t [12];

  triangle_if #(.N(8)) bus ();

  triangle_generator #(.N(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, got timeout, required completion");
    $fatal(1, "watchdog");
  end

  function automatic void push(input int c, input logic [7:0] o, input logic d,
                               input logic p, input logic t, input string nm);
    exp_t e;
    e.cyc = c; e.o = o; e.d = d; e.p = p; e.t = t; e.name = nm;
    sb.push_back(e);
  endfunction

  // Monitor: compare the queued expectation for this cycle, else require quiet strobes.
  always @(negedge clk) begin
    if (sb.size() > 0 && sb[0].cyc < cyc) begin
      n_checks++; n_fail++;
      $display("FAIL %s: expectation for cycle %0d never matched (now cycle %0d)", sb[0].name, sb[0].cyc, cyc);
      void'(sb.pop_front());
    end
    if (sb.size() > 0 && sb[0].cyc == cyc) begin
      exp_t e;
      e = sb.pop_front();
      n_checks++;
      if ({bus.out, bus.dir, bus.at_peak, bus.at_trough} !== {e.o, e.d, e.p, e.t}) begin
        n_fail++;
        $display("FAIL %s: got out=%0d dir=%b pk=%b tr=%b, required out=%0d dir=%b pk=%b tr=%b",
                 e.name, bus.out, bus.dir, bus.at_peak, bus.at_trough, e.o, e.d, e.p, e.t);
      end
    end else if (rst === 1'b0) begin
      n_checks++;
      if (bus.at_peak !== 1'b0 || bus.at_trough !== 1'b0) begin
        n_fail++;
        $display("FAIL idle_strobe@%0d: got pk=%b tr=%b, required pk=0 tr=0", cyc, bus.at_peak, bus.at_trough);
      end
    end
  end

  // One step pulse; response checked after the sampling edge and one cycle later.
  task automatic do_step(input logic [7:0] o, input logic d, input logic p, input logic t,
                         input int gap, input string nm);
    @(negedge clk);
    bus.step = 1'b1;
    push(cyc + 1, o, d, p, t, nm);
    push(cyc + 2, o, d, 1'b0, 1'b0, {nm, "_hold"});
    @(negedge clk);
    bus.step = 1'b0;
    repeat (gap - 2) @(negedge clk);
  endtask

  task automatic do_reset(input string nm);
    @(negedge clk);
    rst = 1'b1;
    push(cyc + 1, 8'd0, 1'b1, 1'b0, 1'b0, nm);
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic run_table(input int n, input string nm);
    for (int i = 0; i < n; i++)
      do_step(t_o[i], t_d[i], t_p[i], t_t[i], 4, $sformatf("%s[%0d]", nm, i));
  endtask

  initial begin
    rst = 1'b1;
    bus.ena = 1'b0;
    bus.step = 1'b0;
    bus.max_level = 8'd10;
    repeat (2) @(negedge clk);
    push(cyc, 8'd0, 1'b1, 1'b0, 1'b0, "reset_state");
    @(negedge clk);
    rst = 1'b0;

    // Reset mid-ramp at out=5, then first step restarts at 1.
    bus.ena = 1'b1;
    for (int i = 1; i <= 5; i++)
      do_step(8'(i), 1'b1, 1'b0, 1'b0, 3, $sformatf("pre_reset_%0d", i));
    do_reset("mid_ramp_reset");
    do_step(8'd1, 1'b1, 1'b0, 1'b0, 3, "post_reset_step");

    // Basic ramp, max_level=3.
    do_reset("reset_ramp3");
    bus.max_level = 8'd3;
`ifdef TRIANGLE_DWELL_EN
    t_o = '{8'd1, 8'd2, 8'd3, 8'd3, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd3, 8'd3};
    t_d = '{1, 1, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0};
    t_p = '{0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0};
    t_t = '{0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
`else
    t_o = '{8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd3, 8'd2, 8'd1, 8'd0};
    t_d = '{1, 1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1};
    t_p = '{0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0};
    t_t = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1};
`endif
    run_table(12, "ramp3");

    // Steps while disabled are lost; re-enabling with step low fakes nothing.
    do_reset("reset_ena");
    bus.ena = 1'b0;
    do_step(8'd0, 1'b1, 1'b0, 1'b0, 3, "ena_low_step");
    bus.ena = 1'b1;
    do_step(8'd1, 1'b1, 1'b0, 1'b0, 3, "ena_high_step");

    // Held step high 10 cycles with ena toggled: exactly one increment.
    do_reset("reset_held");
    @(negedge clk);
    bus.step = 1'b1;
    push(cyc + 1, 8'd1, 1'b1, 1'b0, 1'b0, "held_first");
    for (int i = 1; i < 10; i++) begin
      @(negedge clk);
      if (i == 4) bus.ena = 1'b0;
      if (i == 5) bus.ena = 1'b1;
      push(cyc + 1, 8'd1, 1'b1, 1'b0, 1'b0, $sformatf("held_%0d", i));
    end
    @(negedge clk);
    bus.step = 1'b0;
    @(negedge clk);

    // Clamp: out=7 rising, peak lowered to 4.
    do_reset("reset_clamp");
    bus.max_level = 8'd10;
    for (int i = 1; i <= 7; i++)
      do_step(8'(i), 1'b1, 1'b0, 1'b0, 3, $sformatf("clamp_up_%0d", i));
    bus.max_level = 8'd4;
    do_step(8'd4, 1'b0, 1'b1, 1'b0, 3, "clamp_peak");

    // Degenerate max_level=0.
    do_reset("reset_zero");
    bus.max_level = 8'd0;
    for (int i = 0; i < 5; i++)
      do_step(8'd0, 1'b1, 1'b0, 1'b0, 3, $sformatf("zero_%0d", i));

    // Full-scale peak at 255 without wrap.
    do_reset("reset_full");
    bus.max_level = 8'd255;
    for (int i = 1; i <= 254; i++)
      do_step(8'(i), 1'b1, 1'b0, 1'b0, 2, $sformatf("full_up_%0d", i));
    do_step(8'd255, 1'b0, 1'b1, 1'b0, 3, "full_peak");
`ifdef TRIANGLE_DWELL_EN
    do_step(8'd255, 1'b0, 1'b0, 1'b0, 3, "full_after_peak");
`else
    do_step(8'd254, 1'b0, 1'b0, 1'b0, 3, "full_after_peak");
`endif

    // max_level=2, 8 steps.
    do_reset("reset_ramp2");
    bus.max_level = 8'd2;
`ifdef TRIANGLE_DWELL_EN
    t_o = '{8'd1, 8'd2, 8'd2, 8'd1, 8'd0, 8'd0, 8'd1, 8'd2, 8'd0, 8'd0, 8'd0, 8'd0};
    t_d = '{1, 0, 0, 0, 1, 1, 1, 0, 0, 0, 0, 0};
    t_p = '{0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    t_t = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0};
`else
    t_o = '{8'd1, 8'd2, 8'd1, 8'd0, 8'd1, 8'd2, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
    t_d = '{1, 0, 0, 1, 1, 0, 0, 1, 0, 0, 0, 0};
    t_p = '{0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0};
    t_t = '{0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0};
`endif
    run_table(8, "ramp2");

    repeat (4) @(negedge clk);
    n_checks++;
    if (sb.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, required 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
